// File: rtl/fp32_to_int32_seq.sv
// Serial float32 -> int32 converter: mantissa aligned one bit per cycle, valid/ready on both sides.
// Define FP32_TO_INT_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates toward zero.
module fp32_to_int32_seq (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] res,
    output logic               ovf,
    output logic               inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         count_q, count_d;
    logic               vld_q, vld_d;
    logic signed [31:0] res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               inx_q, inx_d;

    logic [31:0]        mag_q, mag_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic               sign_q, sign_d;
    logic               left_q, left_d;
    logic               special_q, special_d;
    logic signed [31:0] sp_res_q, sp_res_d;
    logic               sp_ovf_q, sp_ovf_d;
    logic               sp_inx_q, sp_inx_d;

    logic               a_s;
    logic [7:0]         a_e;
    logic [22:0]        a_f;
    logic signed [9:0]  a_k;

    logic               dec_special, dec_ovf, dec_inx, dec_left;
    logic signed [31:0] dec_res;
    logic [4:0]         dec_count;

    function automatic logic signed [31:0] apply_sign(input logic s, input logic [31:0] m);
        logic signed [31:0] v;
        v = $signed(m);
        return s ? -v : v;
    endfunction

`ifdef FP32_TO_INT_ROUND_NEAREST_EN
    function automatic logic [31:0] round_mag(input logic [31:0] m, input logic g, input logic st);
        return m + {31'd0, g & (st | m[0])};
    endfunction
`endif

    assign a_s = a[31];
    assign a_e = a[30:23];
    assign a_f = a[22:0];
    assign a_k = $signed({2'b00, a_e}) - 10'sd127;

    // Operand classification; shift counts use e[4:0] since e-150 and 150-e both fit in 5 bits
    always_comb begin
        dec_special = 1'b0;
        dec_res     = '0;
        dec_ovf     = 1'b0;
        dec_inx     = 1'b0;
        dec_left    = 1'b0;
        dec_count   = '0;
        if (a_e == 8'hFF && a_f != 23'd0) begin
            dec_special = 1'b1;
            dec_res     = 32'sh7FFF_FFFF;
            dec_ovf     = 1'b1;
        end else if (a == 32'hCF00_0000) begin
            dec_special = 1'b1;
            dec_res     = 32'sh8000_0000;
        end else if (a_e == 8'hFF || a_k >= 10'sd31) begin
            dec_special = 1'b1;
            dec_res     = a_s ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
            dec_ovf     = 1'b1;
        end else if (a_k < 10'sd0) begin
            dec_special = 1'b1;
            dec_inx     = (a_e != 8'd0) || (a_f != 23'd0);
`ifdef FP32_TO_INT_ROUND_NEAREST_EN
            if (a_k == -10'sd1) begin
                dec_inx = 1'b1;
                if (a_f != 23'd0)
                    dec_res = a_s ? -32'sd1 : 32'sd1;
            end
`endif
        end else if (a_k > 10'sd23) begin
            dec_left  = 1'b1;
            dec_count = a_e[4:0] - 5'd22;
        end else begin
            dec_count = 5'd22 - a_e[4:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        vld_d     = vld_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        inx_d     = inx_q;
        mag_d     = mag_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        sign_d    = sign_q;
        left_d    = left_q;
        special_d = special_q;
        sp_res_d  = sp_res_q;
        sp_ovf_d  = sp_ovf_q;
        sp_inx_d  = sp_inx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = SHIFT;
                    count_d   = dec_count;
                    mag_d     = {8'h00, 1'b1, a_f};
                    guard_d   = 1'b0;
                    sticky_d  = 1'b0;
                    sign_d    = a_s;
                    left_d    = dec_left;
                    special_d = dec_special;
                    sp_res_d  = dec_res;
                    sp_ovf_d  = dec_ovf;
                    sp_inx_d  = dec_inx;
                end
            end
            // Serial alignment: one bit per cycle, right shifts feed guard then sticky
            SHIFT: begin
                if (count_q != 5'd0) begin
                    count_d = count_q - 5'd1;
                    if (left_q) begin
                        mag_d = mag_q << 1;
                    end else begin
                        mag_d    = mag_q >> 1;
                        guard_d  = mag_q[0];
                        sticky_d = sticky_q | guard_q;
                    end
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (special_q) begin
                    res_d = sp_res_q;
                    ovf_d = sp_ovf_q;
                    inx_d = sp_inx_q;
                end else begin
`ifdef FP32_TO_INT_ROUND_NEAREST_EN
                    res_d = apply_sign(sign_q, round_mag(mag_q, guard_q, sticky_q));
`else
                    res_d = apply_sign(sign_q, mag_q);
`endif
                    ovf_d = 1'b0;
                    inx_d = guard_q | sticky_q;
                end
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            vld_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            inx_q   <= inx_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded at accept
    always_ff @(posedge clk) begin
        mag_q     <= mag_d;
        guard_q   <= guard_d;
        sticky_q  <= sticky_d;
        sign_q    <= sign_d;
        left_q    <= left_d;
        special_q <= special_d;
        sp_res_q  <= sp_res_d;
        sp_ovf_q  <= sp_ovf_d;
        sp_inx_q  <= sp_inx_d;
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = vld_q;
    assign res       = res_q;
    assign ovf       = ovf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Randomized bench for fp32_to_int32_seq against an arithmetic (quotient/remainder) reference model.
module tb_fp32_to_int32_seq;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        a = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [31:0] res;
    logic               ovf;
    logic               inexact;

    int n_chk  = 0;
    int n_fail = 0;

    fp32_to_int32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ovf       (ovf),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Value = mant * 2^(k-23); integer part and remainder derived by division.
    task automatic model(input logic [31:0] x, output logic [31:0] r, output logic o,
                         output logic i, output int lat);
        logic   s;
        int     e, k;
        longint mant, q, rem, denom;
        s = x[31];
        e = int'(x[30:23]);
        mant = longint'({1'b1, x[22:0]});
        r = '0; o = 1'b0; i = 1'b0; lat = 2;
        k = e - 127;
        if (e == 255) begin
            o = 1'b1;
            r = (x[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (e == 0 && x[22:0] == 0) begin
            r = '0;
        end else if (k >= 31) begin
            if (x == 32'hCF00_0000) r = 32'h8000_0000;
            else begin
                o = 1'b1;
                r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            if (k >= 23) begin
                q = mant << (k - 23); rem = 0; denom = 1;
                lat = k - 23 + 2;
            end else if (k >= -1) begin
                denom = longint'(1) << (23 - k);
                q = mant / denom; rem = mant % denom;
                lat = (k >= 0) ? (23 - k + 2) : 2;
            end else begin
                q = 0; rem = 1; denom = longint'(1) << 40;
            end
`ifndef FP32_TO_INT_ROUND_NEAREST_EN
            if (k < 0) q = 0;
`else
            if (2 * rem > denom || (2 * rem == denom && q[0])) q = q + 1;
`endif
            i = (rem != 0);
            r = s ? 32'(-q) : 32'(q);
        end
    endtask

    task automatic do_conv(input logic [31:0] x, input int stall);
        logic [31:0] er;
        logic        eo, ei;
        int          lat, n;
        model(x, er, eo, ei, lat);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        for (int w = 0; w < 100 && !in_ready; w++) @(negedge clk);
        check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 200);
        check_eq($sformatf("latency[%08h]", x), n, lat);
        check_eq($sformatf("res[%08h]", x), res, er);
        check_eq($sformatf("ovf[%08h]", x), {31'd0, ovf}, {31'd0, eo});
        check_eq($sformatf("inexact[%08h]", x), {31'd0, inexact}, {31'd0, ei});
        for (int c = 0; c < stall; c++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_res", res, er);
            check_eq("hold_flags", {30'd0, ovf, inexact}, {30'd0, eo, ei});
            check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("release_valid", {31'd0, out_valid}, 32'd0);
        check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    logic [31:0] directed [15] = '{32'h3F80_0000, 32'hC2F6_0000, 32'h4B00_0000, 32'h4EFF_FFFF,
                                   32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'h3FC0_0000,
                                   32'h4020_0000, 32'h3F40_0000, 32'h8000_0000, 32'hFF80_0000,
                                   32'h3F00_0000, 32'h0000_0001, 32'hCF00_0001};

    initial begin
        logic [31:0] x;
        int          seen;
        #2;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_res", res, 32'd0);
        check_eq("rst_flags", {30'd0, ovf, inexact}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Test-plan constants pinned independently of the model
        do_conv(32'h3F80_0000, 0);
        check_eq("one_res", res, 32'h0000_0001);
        do_conv(32'hC2F6_0000, 0);
        check_eq("m123_res", res, 32'hFFFF_FF85);
        do_conv(32'h4EFF_FFFF, 10);
        check_eq("big_res", res, 32'h7FFF_FF80);
        do_conv(32'h4020_0000, 0);
        check_eq("two5_res", res, 32'h0000_0002);

        foreach (directed[j]) do_conv(directed[j], j % 3);

        // Reset while shifting 1.0 aborts the operation
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h3F80_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_res", res, 32'd0);
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("abort_no_result", seen, 32'd0);
        do_conv(32'h4040_0000, 1);
        check_eq("three_res", res, 32'h0000_0003);

        for (int t = 0; t < 200; t++) begin
            x = $urandom;
            case ($urandom_range(0, 9))
                0:       x[30:23] = 8'hFF;
                1:       x[30:23] = 8'h00;
                2:       x[30:23] = 8'd158;
                default: x[30:23] = 8'($urandom_range(120, 160));
            endcase
            do_conv(x, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
